stopwatch_cmd_sched: RTL and testbench

Command scheduler sitting in front of the stopwatch core's start/stop/reset inputs. Two requesters share the core through a req/ack handshake:
- requester 0: front-panel logic.
- requester 1: host register interface.

The block arbitrates between them, checks each command against the core's current status, and issues a single-cycle control pulse. It then waits for the core status to confirm the transition and acknowledges with a pass/fail result.

---
 rtl/stopwatch_cmd_sched.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_cmd_sched.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_cmd_sched.sv
// Command scheduler for the stopwatch core: arbitrates two requesters, checks
// each command against core status, pulses the core and confirms the result.
module stopwatch_cmd_sched #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [1:0] cmd0,
  output logic       ack0,
  input  logic       req1,
  input  logic [1:0] cmd1,
  output logic       ack1,
  output logic       resp_err,
  input  logic [1:0] core_status,
  output logic       sw_start,
  output logic       sw_stop,
  output logic       sw_reset,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {CMD_NOP, CMD_START, CMD_STOP, CMD_RESET} cmd_t;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_RUNNING = 2'b01;
  localparam logic [1:0] ST_PAUSED  = 2'b10;
  localparam logic [7:0] TIMEOUT_LD = 8'(TIMEOUT);

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d, wcmd;
  logic [7:0] cnt_q, cnt_d;
  logic       ptr_q, ptr_d;
  logic       drop_q, drop_d;
  logic       gid_d, win, r0, r1;
  logic       ack_now, ack_err;
  logic       ack0_d, ack1_d, err_d, start_d, stop_d, reset_d;

  function automatic logic cmd_legal(input cmd_t c, input logic [1:0] st);
    unique case (c)
      CMD_START: return (st == ST_IDLE) || (st == ST_PAUSED);
      CMD_STOP:  return st == ST_RUNNING;
      CMD_RESET: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] cmd_target(input cmd_t c);
    unique case (c)
      CMD_START: return ST_RUNNING;
      CMD_STOP:  return ST_PAUSED;
      default:   return ST_IDLE;
    endcase
  endfunction

  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gid_d   = grant_id;
    drop_d  = 1'b0;
    ack_now = 1'b0;
    ack_err = 1'b0;
    start_d = 1'b0;
    stop_d  = 1'b0;
    reset_d = 1'b0;

    // The requester just acknowledged is masked for the handshake-drop cycle.
    r0 = req0 && !(drop_q && !grant_id);
    r1 = req1 && !(drop_q && grant_id);
    if (r0 && r1) begin
      if ((cmd0 == CMD_RESET) != (cmd1 == CMD_RESET)) win = (cmd1 == CMD_RESET);
      else                                            win = ~ptr_q;
    end else begin
      win = r1;
    end
    wcmd = win ? cmd_t'(cmd1) : cmd_t'(cmd0);

    unique case (state_q)
      S_IDLE: begin
        if (r0 || r1) begin
          gid_d = win;
          ptr_d = win;
          cmd_d = wcmd;
          if (wcmd != CMD_NOP && cmd_legal(wcmd, core_status)) begin
            state_d = S_ISSUE;
            start_d = (wcmd == CMD_START);
            stop_d  = (wcmd == CMD_STOP);
            reset_d = (wcmd == CMD_RESET);
          end else begin
            state_d = S_RESP;
            ack_now = 1'b1;
            ack_err = (wcmd != CMD_NOP);
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = TIMEOUT_LD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_status == cmd_target(cmd_q)) begin
          state_d = S_RESP;
          ack_now = 1'b1;
        end else if (cnt_q <= 8'd1) begin
          cnt_d   = 8'd0;
          state_d = S_RESP;
          ack_now = 1'b1;
          ack_err = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        drop_d  = 1'b1;
      end
    endcase

    ack0_d = ack_now && !gid_d;
    ack1_d = ack_now && gid_d;
    err_d  = ack_now && ack_err;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= CMD_NOP;
      cnt_q    <= 8'd0;
      ptr_q    <= 1'b1;
      drop_q   <= 1'b0;
      grant_id <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      resp_err <= 1'b0;
      sw_start <= 1'b0;
      sw_stop  <= 1'b0;
      sw_reset <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      drop_q   <= drop_d;
      grant_id <= gid_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      resp_err <= err_d;
      sw_start <= start_d;
      sw_stop  <= stop_d;
      sw_reset <= reset_d;
      busy     <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_stopwatch_cmd_sched.sv
// Randomized scoreboard bench for stopwatch_cmd_sched with a transaction-level
// model of arbitration, legality, core response and ack timing.
module tb_stopwatch_cmd_sched;

  localparam int T = 4;
  localparam logic [1:0] NOP = 2'd0, START = 2'd1, STOP = 2'd2, RST = 2'd3;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [1:0] cmd0 = 2'd0, cmd1 = 2'd0, status = 2'd0;
  logic       ack0, ack1, resp_err, sw_start, sw_stop, sw_reset, busy, grant_id;

  bit stuck = 1'b0;
  bit m_ptr = 1'b1;
  int edges = 0;
  int total = 0, bad = 0;

  typedef struct {
    bit         id;
    bit         err;
    logic [1:0] pulse;
    int         ack_t;
    int         pulse_t;
  } exp_t;
  exp_t sb[$];

  stopwatch_cmd_sched #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .cmd0(cmd0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .ack1(ack1),
    .resp_err(resp_err), .core_status(status),
    .sw_start(sw_start), .sw_stop(sw_stop), .sw_reset(sw_reset),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle; the bench core reacts to a pulse unless it is held stuck.
  task automatic tick();
    @(negedge clk);
    if (!stuck) begin
      if (sw_start)      status = 2'b01;
      else if (sw_stop)  status = 2'b10;
      else if (sw_reset) status = 2'b00;
    end
  endtask

  function automatic bit legal(input logic [1:0] c, input logic [1:0] s);
    case (c)
      START:   return (s == 2'b00) || (s == 2'b10);
      STOP:    return s == 2'b01;
      RST:     return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Predicts service order, results and observation times for the requests
  // raised at the negedge where edges == t.
  task automatic model_push(input bit p0, input bit p1, input logic [1:0] c0,
                            input logic [1:0] c1, input logic [1:0] st0,
                            input bit stk, input int t0);
    logic [1:0] st, c, target;
    bit win;
    int t, lat;
    exp_t e;
    st = st0;
    t  = t0;
    while (p0 || p1) begin
      if (p0 && p1) win = ((c0 == RST) != (c1 == RST)) ? (c1 == RST) : !m_ptr;
      else          win = p1;
      c = win ? c1 : c0;
      e.id = win;
      e.pulse_t = t + 1;
      if (c != NOP && legal(c, st)) begin
        target = (c == START) ? 2'b01 : (c == STOP) ? 2'b10 : 2'b00;
        if (!stk) st = target;
        e.err   = (st != target);
        e.pulse = c;
        lat     = e.err ? 2 + T : 3;
      end else begin
        e.err   = (c != NOP);
        e.pulse = NOP;
        lat     = 1;
      end
      e.ack_t = t + lat;
      sb.push_back(e);
      t = e.ack_t + 1;
      m_ptr = win;
      if (win) p1 = 1'b0;
      else     p0 = 1'b0;
    end
  endtask

  task automatic wait_acks(input bit late);
    int pend0 = -1, pend1 = -1;
    for (int k = 0; k < 400 && (req0 || req1); k++) begin
      tick();
      if (ack0 && req0 && pend0 < 0) pend0 = late ? 2 : 0;
      if (ack1 && req1 && pend1 < 0) pend1 = late ? 2 : 0;
      if (pend0 >= 0) begin
        if (pend0 == 0) req0 = 1'b0;
        pend0--;
      end
      if (pend1 >= 0) begin
        if (pend1 == 0) req1 = 1'b0;
        pend1--;
      end
    end
    check("round_done", int'(req0 || req1), 0);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    check("busy_idle", busy, 0);
    check("sb_empty", sb.size(), 0);
  endtask

  task automatic round(input bit [1:0] who, input logic [1:0] c0, input logic [1:0] c1,
                       input logic [1:0] st, input bit stk, input bit late);
    tick();
    stuck  = stk;
    status = st;
    cmd0   = c0;
    cmd1   = c1;
    req0   = who[0];
    req1   = who[1];
    model_push(who[0], who[1], c0, c1, st, stk, edges);
    wait_acks(late);
  endtask

  // Monitor: pops an expectation on every ack and checks pulses seen since.
  initial begin
    int np = 0, pt = 0;
    logic [1:0] pk = 2'd0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        np = 0;
        continue;
      end
      if (sw_start || sw_stop || sw_reset) begin
        check("pulse_onehot", int'(sw_start) + int'(sw_stop) + int'(sw_reset), 1);
        np++;
        pk = sw_start ? START : sw_stop ? STOP : RST;
        pt = edges;
      end
      if (ack0 || ack1) begin
        check("ack_onehot", int'(ack0 && ack1), 0);
        check("busy_in_ack", busy, 1);
        check("ack_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("ack_id", ack1, e.id);
          check("grant_id", grant_id, e.id);
          check("resp_err", resp_err, e.err);
          check("ack_time", edges, e.ack_t);
          check("pulse_count", np, int'(e.pulse != NOP));
          if (e.pulse != NOP) begin
            check("pulse_kind", pk, e.pulse);
            check("pulse_time", pt, e.pulse_t);
          end
        end
        np = 0;
      end
    end
  end

  initial begin
    #1;
    check("reset_outputs",
          {ack0, ack1, resp_err, sw_start, sw_stop, sw_reset, busy, grant_id}, 0);
    tick();
    tick();
    rst_n = 1'b1;

    round(2'b01, START, NOP, 2'b00, 1'b0, 1'b0);
    round(2'b10, NOP, STOP, 2'b00, 1'b0, 1'b0);
    round(2'b11, START, START, 2'b00, 1'b0, 1'b1);
    round(2'b11, START, START, 2'b00, 1'b0, 1'b0);
    round(2'b11, START, RST, 2'b00, 1'b0, 1'b1);
    round(2'b01, START, NOP, 2'b00, 1'b1, 1'b0);
    round(2'b10, NOP, RST, 2'b01, 1'b1, 1'b0);
    round(2'b01, NOP, NOP, 2'b11, 1'b0, 1'b0);
    round(2'b11, STOP, START, 2'b11, 1'b0, 1'b1);

    for (int i = 0; i < 80; i++)
      round(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

    // Reset during WAIT: outputs clear at once, no ack, request re-granted.
    tick();
    stuck  = 1'b1;
    status = 2'b00;
    cmd0   = START;
    req0   = 1'b1;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("reset_midflight",
          {ack0, ack1, resp_err, sw_start, sw_stop, sw_reset, busy, grant_id}, 0);
    m_ptr = 1'b1;
    tick();
    tick();
    stuck = 1'b0;
    model_push(1'b1, 1'b0, START, NOP, status, 1'b0, edges);
    rst_n = 1'b1;
    wait_acks(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
